// File: rtl/control_ascensor_pkg.sv
// rtl/control_ascensor_pkg.sv - state encodings and counter-drive constants for the elevator controller
package control_ascensor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DOOR = 2'd1,
    S_UP   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  localparam logic MODO_LOAD  = 1'b1;
  localparam logic MODO_COUNT = 1'b0;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/control_ascensor_req_latch.sv
// rtl/control_ascensor_req_latch.sv - latched floor calls with clear and above/below/here flags
module control_ascensor_req_latch #(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] call,
  input  logic                clr_en,
  input  logic [FLOOR_W-1:0]  clr_floor,
  input  logic [FLOOR_W-1:0]  eval_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                here,
  output logic                above,
  output logic                below
);

  logic [N_FLOORS-1:0] pending_q, pending_d, clr_mask;

  always_comb begin
    clr_mask = '0;
    here     = 1'b0;
    above    = 1'b0;
    below    = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      clr_mask[i] = clr_en && (int'(clr_floor) == i);
      if (int'(eval_floor) == i) here  = pending_q[i];
      if (i > int'(eval_floor))  above = above | pending_q[i];
      if (i < int'(eval_floor))  below = below | pending_q[i];
    end
    // Clear wins, so a call at the open floor is absorbed.
    pending_d = (pending_q | call) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/control_ascensor.sv
// rtl/control_ascensor.sv - elevator control FSM timing door and travel through an external 4-bit counter
import control_ascensor_pkg::*;

module control_ascensor #(
  parameter int         N_FLOORS = 4,
  parameter int         FLOOR_W  = 2,
  parameter logic [3:0] DOOR_T   = 4'd8,
  parameter logic [3:0] TRAVEL_T = 4'd5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] call,
  input  logic [3:0]          Q,
  output logic                enb,
  output logic                modo,
  output logic [3:0]          data,
  output logic [FLOOR_W-1:0]  floor,
  output logic                door_open,
  output logic                moving_up,
  output logic                moving_dn,
  output logic [N_FLOORS-1:0] pending
);

  state_t             state_q, state_d;
  logic               armed_q, armed_d;
  logic               dir_q, dir_d;
  logic [FLOOR_W-1:0] floor_q, eval_floor;
  logic               timed, expire, here, above, below;
  logic [3:0]         t_limit;

  assign timed   = (state_q != S_IDLE);
  assign t_limit = (state_q == S_DOOR) ? DOOR_T : TRAVEL_T;
  // Q is only trusted once the load cycle has passed.
  assign expire  = timed && armed_q && (Q == t_limit);

  always_comb begin
    eval_floor = floor_q;
    if (expire && state_q == S_UP)   eval_floor = floor_q + 1'b1;
    if (expire && state_q == S_DOWN) eval_floor = floor_q - 1'b1;
  end

  control_ascensor_req_latch #(
    .N_FLOORS(N_FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_req_latch (
    .clk       (clk),
    .reset     (reset),
    .call      (call),
    .clr_en    (state_q == S_DOOR),
    .clr_floor (floor_q),
    .eval_floor(eval_floor),
    .pending   (pending),
    .here      (here),
    .above     (above),
    .below     (below)
  );

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    dir_d   = dir_q;
    enb     = 1'b0;
    modo    = MODO_COUNT;
    if (timed) begin
      enb     = 1'b1;
      modo    = armed_q ? MODO_COUNT : MODO_LOAD;
      armed_d = 1'b1;
    end
    if (expire) armed_d = 1'b0;
    if (!timed || expire) begin
      if (here) begin
        state_d = S_DOOR;
      end else if ((dir_q == DIR_UP) ? above : below) begin
        state_d = (dir_q == DIR_UP) ? S_UP : S_DOWN;
      end else if ((dir_q == DIR_UP) ? below : above) begin
        dir_d   = ~dir_q;
        state_d = (dir_q == DIR_UP) ? S_DOWN : S_UP;
      end else begin
        state_d = S_IDLE;
      end
    end
    if (reset) begin
      enb  = 1'b0;
      modo = MODO_COUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      dir_q   <= DIR_UP;
      floor_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      dir_q   <= dir_d;
      floor_q <= eval_floor;
    end
  end

  assign data      = 4'd0;
  assign floor     = floor_q;
  assign door_open = !reset && (state_q == S_DOOR);
  assign moving_up = !reset && (state_q == S_UP);
  assign moving_dn = !reset && (state_q == S_DOWN);

endmodule

// File: tb/tb_control_ascensor.sv
// tb/tb_control_ascensor.sv - randomized and directed bench for control_ascensor with a behavioural counter
module tb_control_ascensor;

  localparam int DOOR_LEN   = 10;
  localparam int TRAVEL_LEN = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] call;
  logic       enb, modo, door_open, moving_up, moving_dn;
  logic [3:0] data, pending;
  logic [1:0] floor;
  logic [3:0] q_cnt = 4'd11;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: 0 idle, 1 door, 2 up, 3 down; m_left counts cycles left in a timed state
  int         m_st    = 0;
  int         m_left  = 0;
  int         m_floor = 0;
  bit         m_up    = 1'b1;
  bit         m_first = 1'b0;
  logic [3:0] m_pend  = 4'd0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (enb) q_cnt <= modo ? data : q_cnt + 4'd1;
  end

  control_ascensor #(
    .N_FLOORS(4),
    .FLOOR_W (2),
    .DOOR_T  (4'd8),
    .TRAVEL_T(4'd5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .call     (call),
    .Q        (q_cnt),
    .enb      (enb),
    .modo     (modo),
    .data     (data),
    .floor    (floor),
    .door_open(door_open),
    .moving_up(moving_up),
    .moving_dn(moving_dn),
    .pending  (pending)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic go_timed(input int st);
    m_st    = st;
    m_left  = (st == 1) ? DOOR_LEN : TRAVEL_LEN;
    m_first = 1'b1;
  endtask

  task automatic decide(input int f);
    bit abv, blw;
    abv = ((m_pend >> (f + 1)) != 4'd0);
    blw = ((m_pend & 4'((1 << f) - 1)) != 4'd0);
    if (m_pend[f]) go_timed(1);
    else if (m_up ? abv : blw) go_timed(m_up ? 2 : 3);
    else if (m_up ? blw : abv) begin
      m_up = ~m_up;
      go_timed(m_up ? 2 : 3);
    end else m_st = 0;
  endtask

  task automatic model_step(input logic [3:0] c, input logic r);
    logic [3:0] np;
    if (r) begin
      m_st = 0; m_left = 0; m_floor = 0; m_up = 1'b1; m_pend = 4'd0; m_first = 1'b0;
      return;
    end
    np = (m_pend | c) & ~((m_st == 1) ? (4'd1 << m_floor) : 4'd0);
    m_first = 1'b0;
    if (m_st == 0) decide(m_floor);
    else begin
      m_left--;
      if (m_left == 0) begin
        if (m_st == 2) m_floor++;
        if (m_st == 3) m_floor--;
        decide(m_floor);
      end
    end
    m_pend = np;
  endtask

  task automatic cyc(input logic [3:0] c, input logic r);
    call  = c;
    reset = r;
    @(posedge clk);
    model_step(c, r);
    @(negedge clk);
    check_val("floor", 8'(floor), 8'(m_floor));
    check_val("pending", 8'(pending), 8'(m_pend));
    check_val("door_open", 8'(door_open), 8'(m_st == 1));
    check_val("moving_up", 8'(moving_up), 8'(m_st == 2));
    check_val("moving_dn", 8'(moving_dn), 8'(m_st == 3));
    check_val("enb", 8'(enb), 8'(m_st != 0));
    check_val("modo", 8'(modo), 8'(m_first));
    check_val("data", 8'(data), 8'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cyc(4'd0, 1'b0);
  endtask

  initial begin
    int n;
    call  = 4'd0;
    reset = 1'b1;

    cyc(4'd0, 1'b1);
    cyc(4'd0, 1'b1);
    cyc(4'd0, 1'b0);
    check_val("rst_floor", 8'(floor), 8'd0);
    check_val("rst_enb", 8'(enb), 8'd0);
    check_val("rst_pending", 8'(pending), 8'd0);

    // single call at the current floor
    cyc(4'b0001, 1'b0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(4'd0, 1'b0);
      if (door_open) n++;
      else if (n > 0) break;
    end
    check_val("door_len", 8'(n), 8'(DOOR_LEN));
    check_val("door_pend", 8'(pending), 8'd0);

    // two floors up, then door
    cyc(4'b0100, 1'b0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(4'd0, 1'b0);
      if (moving_up) n++;
      else if (n > 0) break;
    end
    check_val("up_len", 8'(n), 8'(2 * TRAVEL_LEN));
    check_val("up_floor", 8'(floor), 8'd2);
    check_val("up_door", 8'(door_open), 8'd1);
    idle_cycles(12);

    // calls on both sides while travelling up from floor 1
    cyc(4'd0, 1'b1);
    cyc(4'b0100, 1'b0);
    idle_cycles(9);
    cyc(4'b1001, 1'b0);
    idle_cycles(80);

    // call at the open floor is absorbed; a lower call follows the door
    cyc(4'b0100, 1'b0);
    for (int k = 0; k < 40 && !door_open; k++) cyc(4'd0, 1'b0);
    check_val("door_seen", 8'(door_open), 8'd1);
    idle_cycles(3);
    cyc(4'b0100, 1'b0);
    cyc(4'b0010, 1'b0);
    check_val("absorb_pend", 8'(pending), 8'b0010);
    idle_cycles(40);

    // reset during the third cycle of UP
    cyc(4'd0, 1'b1);
    cyc(4'b1000, 1'b0);
    for (int k = 0; k < 10 && !moving_up; k++) cyc(4'd0, 1'b0);
    check_val("up_seen", 8'(moving_up), 8'd1);
    idle_cycles(2);
    cyc(4'd0, 1'b1);
    cyc(4'd0, 1'b0);
    check_val("mid_rst_floor", 8'(floor), 8'd0);
    check_val("mid_rst_up", 8'(moving_up), 8'd0);
    check_val("mid_rst_enb", 8'(enb), 8'd0);

    for (int k = 0; k < 2500; k++) begin
      logic [3:0] c;
      for (int b = 0; b < 4; b++) c[b] = ($urandom_range(0, 19) == 0);
      cyc(c, $urandom_range(0, 399) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
